serial_adder: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 21 ++
 rtl/serial_adder_if.sv | 23 ++
 rtl/serial_fa_cell.sv | 20 ++
 rtl/serial_adder.sv | 103 ++++++++++
 tb/tb_serial_adder.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding, counter
// sizing and the half-adder primitive the bit cell is built from.
package serial_adder_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Bit counter only has to reach WIDTH-1; keep at least one bit.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

    // Returns {carry, sum}.
    function automatic logic [1:0] half_add(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Start/done handshake and operand/result bus of the serial adder.
// SERIAL_ADDER_OVF_EN adds the signed-overflow flag ovf.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;

    modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`else
    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_fa_cell.sv
// Combinational full-adder bit cell: two half adders plus an OR on the carries.
module serial_fa_cell
    import serial_adder_pkg::*;
(
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    logic [1:0] ha0;
    logic [1:0] ha1;

    always_comb begin
        ha0 = half_add(a_i, b_i);
        ha1 = half_add(ha0[0], c_i);
        s_o = ha1[0];
        c_o = ha0[1] | ha1[1];
    end
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one bit per clock, start/done handshake.
// Optional signed-overflow output enabled by SERIAL_ADDER_OVF_EN.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave bus
);
    localparam int CNT_W = cnt_width(WIDTH);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   a_sh_q;
    logic [WIDTH-1:0]   b_sh_q;
    logic [WIDTH-1:0]   sum_q;
    logic               c_q;
    logic               cout_q;
    logic               fa_s;
    logic               fa_c;
    logic               last_bit;
    logic               accept;
    logic               busy;
    logic               done;

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
    assign accept   = bus.start && (state_q == ST_IDLE || state_q == ST_DONE);

    serial_fa_cell u_fa (
        .a_i (a_sh_q[0]),
        .b_i (b_sh_q[0]),
        .c_i (c_q),
        .s_o (fa_s),
        .c_o (fa_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (bus.start) state_d = ST_RUN;
            ST_RUN:  if (last_bit)  state_d = ST_DONE;
            ST_DONE: state_d = bus.start ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == ST_RUN);
        done = (state_q == ST_DONE);
    end

    // Sum bits enter at the MSB so that after WIDTH shifts bit 0 sits at sum[0].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            a_sh_q <= '0;
            b_sh_q <= '0;
            sum_q  <= '0;
            c_q    <= 1'b0;
            cout_q <= 1'b0;
        end else if (accept) begin
            a_sh_q <= bus.a;
            b_sh_q <= bus.b;
            c_q    <= bus.cin;
            cnt_q  <= '0;
        end else if (state_q == ST_RUN) begin
            sum_q  <= {fa_s, sum_q[WIDTH-1:1]};
            a_sh_q <= {1'b0, a_sh_q[WIDTH-1:1]};
            b_sh_q <= {1'b0, b_sh_q[WIDTH-1:1]};
            c_q    <= fa_c;
            if (last_bit) begin
                cnt_q  <= '0;
                cout_q <= fa_c;
            end else begin
                cnt_q  <= cnt_q + 1'b1;
            end
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_q;

    // On the MSB, c_q is the carry into the MSB and fa_c the carry out of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                         ovf_q <= 1'b0;
        else if (!accept && state_q == ST_RUN && last_bit) ovf_q <= c_q ^ fa_c;
    end

    assign bus.ovf = ovf_q;
`endif

    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8); define SERIAL_ADDER_OVF_EN to
// also check the ovf output.
module tb_serial_adder;
    localparam int WIDTH = 8;

    logic clk;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    serial_adder_if #(.WIDTH(WIDTH)) bus ();

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called #1 after a clock edge; issues a one-cycle start and follows the add
    // to its done pulse. poke_at > 0 pulses a rival start with AA/AA mid-add.
    task automatic run_add(input string tag, input logic [7:0] av, input logic [7:0] bv,
                           input logic cv, input logic [7:0] es, input logic ec,
                           input logic eo, input int poke_at);
        int   seen;
        logic busy_ok;
        bus.a     = av;
        bus.b     = bv;
        bus.cin   = cv;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check_eq({tag, ":busy_acc"}, 32'(bus.busy), 32'd1);
        check_eq({tag, ":done_acc"}, 32'(bus.done), 32'd0);
        busy_ok = 1'b1;
        seen    = -1;
        for (int k = 1; k <= WIDTH + 4; k++) begin
            if (k == poke_at) begin
                bus.start = 1'b1;
                bus.a     = 8'hAA;
                bus.b     = 8'hAA;
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (bus.done) begin
                seen = k;
                break;
            end
            if (!bus.busy) busy_ok = 1'b0;
        end
        check_eq({tag, ":latency"}, 32'(seen), 32'(WIDTH));
        check_eq({tag, ":busy_run"}, 32'(busy_ok), 32'd1);
        check_eq({tag, ":busy_done"}, 32'(bus.busy), 32'd0);
        check_eq({tag, ":sum"}, 32'(bus.sum), 32'(es));
        check_eq({tag, ":cout"}, 32'(bus.cout), 32'(ec));
`ifdef SERIAL_ADDER_OVF_EN
        check_eq({tag, ":ovf"}, 32'(bus.ovf), 32'(eo));
`else
        if (eo === 1'bx) $display("note: unexpected X ovf expectation for %s", tag);
`endif
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, ":busy"}, 32'(bus.busy), 32'd0);
        check_eq({tag, ":done"}, 32'(bus.done), 32'd0);
        check_eq({tag, ":sum"},  32'(bus.sum),  32'd0);
        check_eq({tag, ":cout"}, 32'(bus.cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check_eq({tag, ":ovf"},  32'(bus.ovf),  32'd0);
`endif
    endtask

    initial begin
        int saw_done;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("rst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_zero("rst_rel");

        run_add("add_0f_01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 0);
        @(posedge clk); #1;
        check_eq("pulse_one_cycle", 32'(bus.done), 32'd0);
        check_eq("idle_after_done", 32'(bus.busy), 32'd0);
        check_eq("sum_held", 32'(bus.sum), 32'h10);

        run_add("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0);
        @(posedge clk); #1;
        run_add("add_ff_00_c1", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 0);
        @(posedge clk); #1;

        run_add("busy_ignore", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 3);
        // Still in the DONE cycle: next start is back-to-back.
        run_add("back2back", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 0);
        @(posedge clk); #1;

        run_add("ovf_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0);
        @(posedge clk); #1;

        // Abort an add at bit 4.
        bus.a     = 8'hFF;
        bus.b     = 8'hFF;
        bus.cin   = 1'b0;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check_zero("abort");
        @(negedge clk);
        rst_n    = 1'b1;
        saw_done = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.done) saw_done = 1;
        end
        check_eq("abort_no_done", 32'(saw_done), 32'd0);
        check_eq("abort_idle", 32'(bus.busy), 32'd0);

        run_add("after_abort", 8'h3C, 8'h4B, 1'b1, 8'h88, 1'b0, 1'b1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
